// File: rtl/spc_pkg.sv
// Shared definitions for the serial-to-parallel symbol collector.
// Holds the constellation mode encodings and the mode -> bits-per-symbol map.
package spc_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'b00,
    MODE_QPSK  = 2'b01,
    MODE_16QAM = 2'b10,
    MODE_64QAM = 2'b11
  } spc_mode_e;

  // Bits per symbol for each constellation.
  function automatic logic [2:0] mode_to_n(input spc_mode_e m);
    case (m)
      MODE_BPSK:  mode_to_n = 3'd1;
      MODE_QPSK:  mode_to_n = 3'd2;
      MODE_16QAM: mode_to_n = 3'd4;
      default:    mode_to_n = 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/multi_mode_spc.sv
// Multi-mode serial-to-parallel converter.
// Collects qualified serial bits into BPSK/QPSK/16QAM/64QAM symbols and
// emits each one as a registered, right-aligned word with a one-cycle pulse.
// Ports:
//   clk, rst        clock, async active-low reset
//   en, din         serial bit and its valid qualifier
//   mode            constellation select, sampled at symbol start
//   flush           emit a partially collected symbol, zero-padded
//   sym_out         collected symbol, bits above N are zero
//   sym_valid       one-cycle pulse for each new sym_out
//   sym_partial     set with sym_valid when the symbol came from flush
//   bit_cnt         bits collected for the current symbol
module multi_mode_spc
  import spc_pkg::*;
#(
  parameter int MAX_BITS  = 6,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                din,
  input  logic [1:0]          mode,
  input  logic                flush,
  output logic [MAX_BITS-1:0] sym_out,
  output logic                sym_valid,
  output logic                sym_partial,
  output logic [2:0]          bit_cnt
);

  if (MAX_BITS < 6) begin : g_bad_max_bits
    $error("multi_mode_spc: MAX_BITS must be >= 6");
  end

  spc_mode_e           act_mode;
  logic [MAX_BITS-1:0] shreg;

  spc_mode_e           cur_mode;
  logic [2:0]          n;
  logic [2:0]          cnt_nxt;
  logic [2:0]          pad;
  logic [MAX_BITS-1:0] shreg_nxt;
  logic                full;
  logic                part;
  logic [MAX_BITS-1:0] emit_val;

  always_comb begin
    // At a symbol boundary the live mode input decides N, so a BPSK bit
    // completes on the very edge that starts it.
    cur_mode  = (bit_cnt == 3'd0) ? spc_mode_e'(mode) : act_mode;
    n         = mode_to_n(cur_mode);
    cnt_nxt   = bit_cnt;
    shreg_nxt = shreg;
    if (en) begin
      cnt_nxt = bit_cnt + 3'd1;
      if (MSB_FIRST != 0)
        shreg_nxt = {shreg[MAX_BITS-2:0], din};
      else
        shreg_nxt = shreg | ({{(MAX_BITS-1){1'b0}}, din} << bit_cnt);
    end
    // The bit arriving with flush is included first; if it completes the
    // symbol, the result is a normal full symbol.
    full = en && (cnt_nxt == n);
    part = flush && !full && (cnt_nxt != 3'd0);
    pad  = n - cnt_nxt;
    // MSB-first bits sit right-aligned in the shifter; a partial symbol has
    // to be moved up so the missing trailing bits become zero LSBs.
    if (part && (MSB_FIRST != 0))
      emit_val = shreg_nxt << pad;
    else
      emit_val = shreg_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_mode    <= MODE_QPSK;
      shreg       <= '0;
      bit_cnt     <= 3'd0;
      sym_out     <= '0;
      sym_valid   <= 1'b0;
      sym_partial <= 1'b0;
    end else begin
      if (bit_cnt == 3'd0) act_mode <= spc_mode_e'(mode);
      if (full || part) begin
        sym_out     <= emit_val;
        sym_valid   <= 1'b1;
        sym_partial <= part;
        bit_cnt     <= 3'd0;
        shreg       <= '0;
      end else begin
        sym_valid   <= 1'b0;
        sym_partial <= 1'b0;
        bit_cnt     <= cnt_nxt;
        shreg       <= shreg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_multi_mode_spc.sv
// Bench for multi_mode_spc: one instance per bit order, driven in parallel,
// checked against a queue-based symbol model plus fixed vector tables.
module tb_multi_mode_spc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, din = 1'b0, flush = 1'b0;
  logic [1:0] mode = 2'b01;

  logic [5:0] sym1, sym0;
  logic       v1, p1, v0, p0;
  logic [2:0] c1, c0;

  always #5 clk = ~clk;

  multi_mode_spc #(.MAX_BITS(6), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .din(din), .mode(mode), .flush(flush),
    .sym_out(sym1), .sym_valid(v1), .sym_partial(p1), .bit_cnt(c1));

  multi_mode_spc #(.MAX_BITS(6), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .din(din), .mode(mode), .flush(flush),
    .sym_out(sym0), .sym_valid(v0), .sym_partial(p0), .bit_cnt(c0));

  int n_pass = 0;
  int n_total = 0;
  int pulses0 = 0;
  int pulses1 = 0;

  // Reference model: list of received bits and symbol length.
  int         mq[$];
  int         mn = 2;
  logic [5:0] e_sym1 = '0, e_sym0 = '0;
  logic       e_v = 1'b0, e_p = 1'b0;
  logic [2:0] e_cnt = '0;

  function automatic int bits_for(input logic [1:0] m);
    case (m)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 6;
    endcase
  endfunction

  task automatic model_emit(input logic partial);
    e_sym1 = '0;
    e_sym0 = '0;
    foreach (mq[k]) begin
      e_sym1[mn-1-k] = mq[k][0];
      e_sym0[k]      = mq[k][0];
    end
    e_v = 1'b1;
    e_p = partial;
    mq.delete();
  endtask

  task automatic model_step(input logic e, input logic d, input logic [1:0] m, input logic f);
    if (mq.size() == 0) mn = bits_for(m);
    if (e) mq.push_back(int'(d));
    e_v = 1'b0;
    e_p = 1'b0;
    if (mq.size() == mn) model_emit(1'b0);
    else if (f && mq.size() > 0) model_emit(1'b1);
    e_cnt = 3'(mq.size());
  endtask

  task automatic model_reset();
    mq.delete();
    e_sym1 = '0; e_sym0 = '0; e_v = 1'b0; e_p = 1'b0; e_cnt = '0;
  endtask

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got sym/v/p/cnt=%h required %h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  // One clock: drive, step the model on the edge, sample 1ns later.
  task automatic cyc(input logic e, input logic d, input logic [1:0] m, input logic f);
    en = e; din = d; mode = m; flush = f;
    @(posedge clk);
    model_step(e, d, m, f);
    #1;
    pulses1 += int'(v1);
    pulses0 += int'(v0);
    check("model_msb", {sym1, v1, p1, c1}, {e_sym1, e_v, e_p, e_cnt});
    check("model_lsb", {sym0, v0, p0, c0}, {e_sym0, e_v, e_p, e_cnt});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = 1'b0; flush = 1'b0;
    #3;
    model_reset();
    check("reset_msb", {sym1, v1, p1, c1}, 11'd0);
    check("reset_lsb", {sym0, v0, p0, c0}, 11'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic       en, din, flush;
    logic [1:0] mode;
    logic [5:0] sym;
    logic       v, p;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, input logic d, input logic [1:0] m, input logic f,
                              input logic [5:0] s, input logic v, input logic p, input logic [2:0] c);
    vec_t r;
    r.en = e; r.din = d; r.mode = m; r.flush = f;
    r.sym = s; r.v = v; r.p = p; r.cnt = c;
    return r;
  endfunction

  initial begin
    // QPSK 1,0,1,1
    tbl.push_back(mk(1,1,1,0, 6'd0,  0,0,1));
    tbl.push_back(mk(1,0,1,0, 6'd2,  1,0,0));
    tbl.push_back(mk(1,1,1,0, 6'd2,  0,0,1));
    tbl.push_back(mk(1,1,1,0, 6'd3,  1,0,0));
    // 16QAM 1,1,0,1
    tbl.push_back(mk(1,1,2,0, 6'd3,  0,0,1));
    tbl.push_back(mk(1,1,2,0, 6'd3,  0,0,2));
    tbl.push_back(mk(1,0,2,0, 6'd3,  0,0,3));
    tbl.push_back(mk(1,1,2,0, 6'd13, 1,0,0));
    // 64QAM 1,0,1,0,1,1
    tbl.push_back(mk(1,1,3,0, 6'd13, 0,0,1));
    tbl.push_back(mk(1,0,3,0, 6'd13, 0,0,2));
    tbl.push_back(mk(1,1,3,0, 6'd13, 0,0,3));
    tbl.push_back(mk(1,0,3,0, 6'd13, 0,0,4));
    tbl.push_back(mk(1,1,3,0, 6'd13, 0,0,5));
    tbl.push_back(mk(1,1,3,0, 6'd43, 1,0,0));
    // QPSK, mode switched to 64QAM mid-symbol: still a 2-bit symbol
    tbl.push_back(mk(1,1,1,0, 6'd43, 0,0,1));
    tbl.push_back(mk(1,0,3,0, 6'd2,  1,0,0));
    // next symbol takes 6 bits
    tbl.push_back(mk(1,1,3,0, 6'd2,  0,0,1));
    tbl.push_back(mk(1,1,3,0, 6'd2,  0,0,2));
    tbl.push_back(mk(1,1,3,0, 6'd2,  0,0,3));
    tbl.push_back(mk(1,1,3,0, 6'd2,  0,0,4));
    tbl.push_back(mk(1,1,3,0, 6'd2,  0,0,5));
    tbl.push_back(mk(1,0,3,0, 6'd62, 1,0,0));
    // 16QAM 1,0,1 then flush
    tbl.push_back(mk(1,1,2,0, 6'd62, 0,0,1));
    tbl.push_back(mk(1,0,2,0, 6'd62, 0,0,2));
    tbl.push_back(mk(1,1,2,0, 6'd62, 0,0,3));
    tbl.push_back(mk(0,0,2,1, 6'd10, 1,1,0));
    // flush with nothing collected: no pulse
    tbl.push_back(mk(0,0,2,1, 6'd10, 0,0,0));
    // flush together with the completing bit: full symbol
    tbl.push_back(mk(1,1,1,0, 6'd10, 0,0,1));
    tbl.push_back(mk(1,1,1,1, 6'd3,  1,0,0));
    // BPSK back-to-back
    tbl.push_back(mk(1,1,0,0, 6'd1,  1,0,0));
    tbl.push_back(mk(1,0,0,0, 6'd0,  1,0,0));
    tbl.push_back(mk(1,1,0,0, 6'd1,  1,0,0));
    // 16QAM flush with the 2nd bit on the same edge: 2 of 4 bits
    tbl.push_back(mk(1,1,2,0, 6'd1,  0,0,1));
    tbl.push_back(mk(1,1,2,1, 6'd12, 1,1,0));
  end

  initial begin
    #1;
    do_reset();

    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].din, tbl[i].mode, tbl[i].flush);
      check($sformatf("tbl[%0d]", i), {sym1, v1, p1, c1},
            {tbl[i].sym, tbl[i].v, tbl[i].p, tbl[i].cnt});
    end

    // LSB-first 16QAM 1,1,0,0 with an en gap after bit 2
    do_reset();
    pulses0 = 0;
    pulses1 = 0;
    cyc(1,1,2,0);
    cyc(1,1,2,0);
    cyc(0,0,3,0);
    cyc(0,1,3,0);
    cyc(1,0,2,0);
    cyc(1,0,2,0);
    check("gap_lsb", {sym0, 5'd0}, {6'd3, 5'd0});
    check("gap_msb", {sym1, 5'd0}, {6'd12, 5'd0});
    cyc(0,0,2,0);
    check_int("gap_pulses", pulses0, 1);

    // Reset mid-symbol in 64QAM, asserted between edges
    pulses1 = 0;
    cyc(1,1,3,0);
    cyc(1,0,3,0);
    cyc(1,1,3,0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("midrst_msb", {sym1, v1, p1, c1}, 11'd0);
    check("midrst_lsb", {sym0, v0, p0, c0}, 11'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) cyc(1,1,3,0);
    check("after_rst", {sym1, v1, p1, c1}, {6'd63, 1'b1, 1'b0, 3'd0});
    check_int("midrst_pulses", pulses1, 1);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      cyc(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), logic'($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_mode_spc.md
MULTI_MODE_SPC -- requirements
Module: multi_mode_spc

Interface
REQ-001 Parameter MAX_BITS, default 6, sets sym_out width; SHALL be >= 6, elaboration error otherwise.
REQ-002 Parameter MSB_FIRST, default 1; 1 = first serial bit becomes symbol MSB, 0 = first serial bit becomes bit 0.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  din valid qualifier; bit sampled only when en=1.
REQ-006 din  input  1  serial data bit.
REQ-007 mode  input  2  constellation select: 00 BPSK (N=1), 01 QPSK (N=2), 10 16QAM (N=4), 11 64QAM (N=6).
REQ-008 flush  input  1  emit any partially collected symbol, zero-padded.
REQ-009 sym_out  output  MAX_BITS  registered symbol, right-aligned, bits [MAX_BITS-1:N] zero.
REQ-010 sym_valid  output  1  one-cycle pulse marking a new sym_out.
REQ-011 sym_partial  output  1  high with sym_valid when the symbol came from flush.
REQ-012 bit_cnt  output  3  bits collected for current symbol, 0..5.

Function
REQ-013 Bit counter SHALL increment on each edge with en=1 and wrap to 0 after the N-th bit of the active symbol.
REQ-014 Active mode SHALL be loaded from mode on every edge where bit_cnt=0; mode changes while bit_cnt>0 SHALL be ignored until the symbol boundary.
REQ-015 On the edge where bit_cnt=0, N SHALL be decoded from the live mode input, so BPSK completes in the same edge.
REQ-016 On the edge sampling the N-th bit, sym_out SHALL load the completed symbol and sym_valid SHALL be 1 for exactly the following cycle (latency: 1 edge after last bit).
REQ-017 MSB_FIRST=1: k-th received bit (k=0 first) SHALL occupy sym_out[N-1-k]; MSB_FIRST=0: sym_out[k].
REQ-018 sym_out SHALL hold its value between sym_valid pulses; sym_valid and sym_partial SHALL be 0 otherwise.
REQ-019 en=0 cycles SHALL leave counter and shift register unchanged (gaps tolerated).
REQ-020 flush=1 with bit_cnt>0 SHALL emit collected bits, unreceived positions zero, sym_valid=1, sym_partial=1, bit_cnt->0.
REQ-021 flush=1 with en=1 on same edge: din SHALL be included first; if it completes the symbol, output is a full symbol with sym_partial=0.
REQ-022 flush=1 with bit_cnt=0 and en=0 SHALL be a no-op (no pulse).
REQ-023 Back-to-back symbols SHALL be supported with no idle cycle; sym_valid may assert on consecutive cycles in BPSK.

Reset
REQ-024 rst=0 SHALL asynchronously clear sym_out, sym_valid, sym_partial, bit_cnt, shift register to 0 and set active mode to 01 (QPSK).
REQ-025 Reset mid-symbol SHALL discard the partial symbol with no sym_valid pulse; first en bit after release starts a new symbol.

Structure
REQ-026 Mode encodings (MODE_BPSK..MODE_64QAM) and a mode-to-N function SHALL live in shared package spc_pkg.
REQ-027 Block SHALL be one module; no sub-module is warranted.

Verification
REQ-028 QPSK, MSB_FIRST=1, en=1, din 1,0,1,1 -> sym_out 000010 then 000011, sym_valid pulses after bits 2 and 4.
REQ-029 16QAM din 1,1,0,1 then 64QAM din 1,0,1,0,1,1 -> sym_out 001101 then 101011, sym_partial=0.
REQ-030 QPSK, mode set to 11 after first bit 1, second bit 0 -> sym_out 000010 emitted as QPSK; next symbol uses 6 bits.
REQ-031 16QAM din 1,0,1 then flush -> sym_out 001010, sym_valid=1, sym_partial=1, bit_cnt=0.
REQ-032 MSB_FIRST=0, 16QAM din 1,1,0,0 with en=0 gap after bit 2 -> sym_out 000011, single pulse.
REQ-033 64QAM, rst=0 after 3 bits -> all outputs 0, no pulse; next 6 bits 111111 -> sym_out 111111.
